// File: rtl/nibble_uart_tx.sv
// nibble_uart_tx: drains a 4-bit nibble FIFO and sends each nibble as an
// asynchronous serial frame: start bit, 4 data bits LSB first, an optional
// even-parity bit and a stop bit.
// Optional feature macro: NIBTX_PARITY_EN. When it is defined, the PARITY
// state and the parity register are compiled in and each frame is 7 bits
// long. Without it, each frame is 6 bits long.
// All outputs are decoded from registered state, so no input reaches an
// output combinationally.

module nibble_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [3:0] fifo_rdata,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] ONE  = TW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
`ifdef NIBTX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif
  localparam logic [2:0] STOP   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic [7:0]    count_q, count_d;
  logic          bit_end;
`ifdef NIBTX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign bit_end = (timer_q == LAST);

  // Next-state logic: frame sequencing, bit timing and the shift register
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    count_d   = count_q;
`ifdef NIBTX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_idx_d = 2'd0;
        if (en && !fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_rdata;
`ifdef NIBTX_PARITY_EN
        parity_d = ^fifo_rdata;
`endif
        timer_d = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = 2'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[3:1]};
          if (bit_idx_q == 2'd3) begin
            bit_idx_d = 2'd0;
`ifdef NIBTX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 2'd1;
          end
        end else begin
          timer_d = timer_q + ONE;
        end
      end
`ifdef NIBTX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = STOP;
        end else begin
          timer_d = timer_q + ONE;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          if (en && !fifo_empty) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= 2'd0;
      shift_q   <= 4'd0;
      done_q    <= 1'b0;
      count_q   <= 8'd0;
`ifdef NIBTX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      count_q   <= count_d;
`ifdef NIBTX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Line level decoded from the current state; idle and gap cycles are high
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START: tx = 1'b0;
      DATA:  tx = shift_q[0];
`ifdef NIBTX_PARITY_EN
      PARITY: tx = parity_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign fifo_re     = (state_q == FETCH);
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_nibble_uart_tx.sv
// tb_nibble_uart_tx: randomized self-checking bench for nibble_uart_tx.
// Expected waveforms come from a frame-level model: each nibble becomes a
// list of line bits, frames are placed on a timeline of CLKS_PER_BIT-wide
// bit slots with a two-cycle fetch/load lead-in.

module tb_nibble_uart_tx;

  localparam int C = 4;
`ifdef NIBTX_PARITY_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int P = NB * C + 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       fifo_empty;
  logic [3:0] fifo_rdata;
  logic       fifo_re;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  int nTests = 0;
  int nFail = 0;
  int underflow = 0;
  logic [7:0] expCount = 8'd0;

  logic [3:0] fifoQ[$];
  logic txTr[$], reTr[$], busyTr[$], doneTr[$];
  logic [7:0] cntTr[$];
  logic expTx[$], expRe[$], expBusy[$], expDone[$];
  logic [7:0] expCnt[$];

  nibble_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_re(fifo_re),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line bit j of the frame carrying nibble n
  function automatic logic frameBit(input logic [3:0] n, input int j);
    if (j == 0) return 1'b0;
    if (j <= 4) return n[j-1];
`ifdef NIBTX_PARITY_EN
    if (j == 5) return ^n;
`endif
    return 1'b1;
  endfunction

  function automatic int firstDiff(input logic a[$], input logic b[$]);
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic int firstDiff8(input logic [7:0] a[$], input logic [7:0] b[$]);
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // One clock: the FIFO model pops on a read seen before the edge, then outputs are sampled
  task automatic step();
    logic reBefore;
    reBefore = fifo_re;
    @(posedge clk);
    #1;
    if (reBefore) begin
      if (fifoQ.size() == 0) underflow++;
      else fifo_rdata = fifoQ.pop_front();
    end
    fifo_empty = (fifoQ.size() == 0);
    txTr.push_back(tx);
    reTr.push_back(fifo_re);
    busyTr.push_back(busy);
    doneTr.push_back(frame_done);
    cntTr.push_back(frame_count);
  endtask

  task automatic capture(input int n, input int dropAt);
    txTr.delete(); reTr.delete(); busyTr.delete(); doneTr.delete(); cntTr.delete();
    for (int i = 0; i < n; i++) begin
      step();
      if (i == dropAt) en = 1'b0;
    end
  endtask

  task automatic pushNibbles(input logic [3:0] nibs[$]);
    foreach (nibs[k]) fifoQ.push_back(nibs[k]);
    fifo_empty = (fifoQ.size() == 0);
  endtask

  // Frame-level reference: frames queued before enable start back to back
  task automatic model(input logic [3:0] nibs[$], input int len);
    logic [7:0] cnt;
    logic t, r, b, d;
    int s;
    cnt = expCount;
    expTx.delete(); expRe.delete(); expBusy.delete(); expDone.delete(); expCnt.delete();
    for (int i = 0; i < len; i++) begin
      t = 1'b1; r = 1'b0; b = 1'b0; d = 1'b0;
      for (int f = 0; f < nibs.size(); f++) begin
        s = 2 + f * P;
        if (i >= s && i < s + NB * C) t = frameBit(nibs[f], (i - s) / C);
        if (i == s - 2) r = 1'b1;
        if (i >= s - 2 && i < s + NB * C) b = 1'b1;
        if (i == s + NB * C) d = 1'b1;
      end
      if (d) cnt = cnt + 8'd1;
      expTx.push_back(t); expRe.push_back(r); expBusy.push_back(b);
      expDone.push_back(d); expCnt.push_back(cnt);
    end
    expCount = cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    fifoQ.push_back(4'h9);
    fifo_empty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      nTests++;
      if ({tx, fifo_re, busy, frame_done, frame_count} !== {4'b1000, 8'h00}) begin
        nFail++;
        $display("[TB] FAIL reset_hold cycle %0d: got tx/re/busy/done/cnt %b%b%b%b/%0d, expected 1000/0",
                 i, tx, fifo_re, busy, frame_done, frame_count);
      end
    end
    en = 1'b0;
    fifoQ.delete();
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    expCount = 8'd0;
    capture(4, -1);
    nTests++;
    if (reTr.sum() with (int'(item)) != 0 || busy !== 1'b0 || tx !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_release: got busy %b tx %b, expected busy 0 tx 1 and no reads", busy, tx);
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] nibs[$];
    logic [6:0] pat, obs;
    int d, len, ones, doneAt;
    nibs = '{4'b1010};
`ifdef NIBTX_PARITY_EN
    pat = 7'b1010100;
`else
    pat = 7'b0110100;
`endif
    len = NB * C + 6;
    pushNibbles(nibs);
    en = 1'b1;
    capture(len, -1);
    model(nibs, len);
    obs = 7'd0;
    for (int j = 0; j < NB; j++) obs[j] = txTr[2 + j * C + C / 2];
    nTests++;
    if (obs !== pat) begin
      nFail++;
      $display("[TB] FAIL single_bits: got %b, expected %b", obs, pat);
    end
    ones = 0; doneAt = -1;
    foreach (doneTr[i]) if (doneTr[i] === 1'b1) begin ones++; doneAt = i; end
    nTests++;
    if (ones != 1 || doneAt != 2 + NB * C) begin
      nFail++;
      $display("[TB] FAIL single_done: got %0d pulses at %0d, expected 1 at %0d", ones, doneAt, 2 + NB * C);
    end
    d = firstDiff(txTr, expTx);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL single_tx cycle %0d: got %b, expected %b", d, txTr[d], expTx[d]); end
    d = firstDiff(reTr, expRe);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL single_re cycle %0d: got %b, expected %b", d, reTr[d], expRe[d]); end
    d = firstDiff(busyTr, expBusy);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL single_busy cycle %0d: got %b, expected %b", d, busyTr[d], expBusy[d]); end
    nTests++;
    if (frame_count !== 8'd1) begin
      nFail++;
      $display("[TB] FAIL single_count: got %0d, expected 1", frame_count);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] nibs[$];
    int d, len;
    nibs = '{4'hF, 4'h0, 4'h5};
    len = 3 * P + 6;
    pushNibbles(nibs);
    en = 1'b1;
    capture(len, -1);
    model(nibs, len);
    d = firstDiff(txTr, expTx);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL b2b_tx cycle %0d: got %b, expected %b", d, txTr[d], expTx[d]); end
    d = firstDiff(reTr, expRe);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL b2b_re cycle %0d: got %b, expected %b", d, reTr[d], expRe[d]); end
    d = firstDiff(busyTr, expBusy);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL b2b_busy cycle %0d: got %b, expected %b", d, busyTr[d], expBusy[d]); end
    d = firstDiff(doneTr, expDone);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL b2b_done cycle %0d: got %b, expected %b", d, doneTr[d], expDone[d]); end
    d = firstDiff8(cntTr, expCnt);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL b2b_count cycle %0d: got %0d, expected %0d", d, cntTr[d], expCnt[d]); end
    en = 1'b0;
  endtask

  task automatic test_random_frames();
    logic [3:0] nibs[$];
    int d, len, gap;
    for (int r = 0; r < 4; r++) begin
      nibs.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) nibs.push_back(4'($urandom));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      len = nibs.size() * P + 4;
      pushNibbles(nibs);
      en = 1'b1;
      capture(len, -1);
      model(nibs, len);
      d = firstDiff(txTr, expTx);
      nTests++;
      if (d >= 0) begin nFail++; $display("[TB] FAIL rand%0d_tx cycle %0d: got %b, expected %b", r, d, txTr[d], expTx[d]); end
      d = firstDiff(reTr, expRe);
      nTests++;
      if (d >= 0) begin nFail++; $display("[TB] FAIL rand%0d_re cycle %0d: got %b, expected %b", r, d, reTr[d], expRe[d]); end
      d = firstDiff8(cntTr, expCnt);
      nTests++;
      if (d >= 0) begin nFail++; $display("[TB] FAIL rand%0d_count cycle %0d: got %0d, expected %0d", r, d, cntTr[d], expCnt[d]); end
      en = 1'b0;
    end
  endtask

  task automatic test_en_drop();
    logic [3:0] nibs[$];
    logic [3:0] first[$];
    int d, len;
    nibs = '{4'($urandom), 4'($urandom)};
    first = '{nibs[0]};
    len = P + 10;
    pushNibbles(nibs);
    en = 1'b1;
    capture(len, 2 + 2 * C);
    model(first, len);
    d = firstDiff(txTr, expTx);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL endrop_tx cycle %0d: got %b, expected %b", d, txTr[d], expTx[d]); end
    d = firstDiff(reTr, expRe);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL endrop_re cycle %0d: got %b, expected %b", d, reTr[d], expRe[d]); end
    d = firstDiff(busyTr, expBusy);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL endrop_busy cycle %0d: got %b, expected %b", d, busyTr[d], expBusy[d]); end
    nTests++;
    if (fifoQ.size() != 1) begin
      nFail++;
      $display("[TB] FAIL endrop_fifo: got %0d entries left, expected 1", fifoQ.size());
    end
    fifoQ.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] none[$];
    int d;
    pushNibbles('{4'($urandom)});
    en = 1'b1;
    capture(2 + 2 * C, -1);
    #2;
    rst_n = 1'b0;
    #1;
    nTests++;
    if ({tx, busy, frame_count} !== {2'b10, 8'h00}) begin
      nFail++;
      $display("[TB] FAIL midreset_async: got tx %b busy %b cnt %0d, expected tx 1 busy 0 cnt 0", tx, busy, frame_count);
    end
    expCount = 8'd0;
    fifoQ.delete();
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    capture(10, -1);
    none.delete();
    model(none, 10);
    d = firstDiff(reTr, expRe);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL midreset_re cycle %0d: got %b, expected %b", d, reTr[d], expRe[d]); end
    d = firstDiff(txTr, expTx);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL midreset_tx cycle %0d: got %b, expected %b", d, txTr[d], expTx[d]); end
    en = 1'b0;
  endtask

  task automatic test_count_wrap();
    logic [3:0] nibs[$];
    int d, len;
    for (int k = 0; k < 256; k++) nibs.push_back(4'($urandom));
    len = 256 * P + 4;
    pushNibbles(nibs);
    en = 1'b1;
    capture(len, -1);
    model(nibs, len);
    d = firstDiff8(cntTr, expCnt);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL wrap_count cycle %0d: got %0d, expected %0d", d, cntTr[d], expCnt[d]); end
    d = firstDiff(txTr, expTx);
    nTests++;
    if (d >= 0) begin nFail++; $display("[TB] FAIL wrap_tx cycle %0d: got %b, expected %b", d, txTr[d], expTx[d]); end
    nTests++;
    if (frame_count !== 8'd0) begin
      nFail++;
      $display("[TB] FAIL wrap_final: got %0d, expected 0", frame_count);
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = 4'h0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_frames();
    test_en_drop();
    test_reset_mid_frame();
    test_count_wrap();
    nTests++;
    if (underflow != 0) begin
      nFail++;
      $display("[TB] FAIL fifo_underflow: got %0d reads while empty, expected 0", underflow);
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
